// File: rtl/mpsoc_sysid_checker.sv
// mpsoc_sysid_checker: Avalon-MM read master that fetches and verifies the system-ID and timestamp words
//   clock, reset_n         : system clock, asynchronous active-low reset
//   start                  : launches a check when idle
//   busy, done             : check in progress / one-cycle completion pulse
//   pass, fail_flags       : verdict, {timeout, ts mismatch, id mismatch}, held until next start
//   id_value, ts_value     : captured words (0 if never read)
//   m_*                    : Avalon-MM read master port
module mpsoc_sysid_checker #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd1,
  parameter logic [31:0] EXPECTED_TS    = 32'd1716034729,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_flags,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);
  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE} state_t;
  state_t state;
  logic [15:0] cnt;
  logic id_rd, in_req, in_wait, is_id, accept, cmpl, tmo, id_bad, ts_bad;
  always_comb begin
    in_req  = state == ID_REQ || state == TS_REQ;
    in_wait = state == ID_WAIT || state == TS_WAIT;
    is_id   = state == ID_REQ || state == ID_WAIT;
    accept  = in_req && !m_waitrequest;
    cmpl    = in_wait ? m_readdatavalid : accept && m_readdatavalid;
    tmo     = (in_req || in_wait) && TIMEOUT_CYCLES != 16'd0 && cnt == TIMEOUT_CYCLES - 16'd1 && !cmpl;
    id_bad  = id_rd && id_value != EXPECTED_ID;
    ts_bad  = m_readdata != EXPECTED_TS;
  end
  // verdict is computed on the edge entering DONE so it is valid alongside the done pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_flags <= '0;
      id_value   <= '0;
      ts_value   <= '0;
      m_read     <= 1'b0;
      m_address  <= BASE_ADDR;
      cnt        <= '0;
      id_rd      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pass       <= 1'b0;
          fail_flags <= '0;
          id_value   <= '0;
          ts_value   <= '0;
          id_rd      <= 1'b0;
          busy       <= 1'b1;
          m_read     <= 1'b1;
          m_address  <= BASE_ADDR;
          cnt        <= '0;
          state      <= ID_REQ;
        end
        ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
          cnt <= cnt + 16'd1;
          if (accept) m_read <= 1'b0;
          if (cmpl && is_id) begin
            id_value  <= m_readdata;
            id_rd     <= 1'b1;
            m_read    <= 1'b1;
            m_address <= BASE_ADDR + 32'd4;
            cnt       <= '0;
            state     <= TS_REQ;
          end else if (cmpl) begin
            ts_value   <= m_readdata;
            fail_flags <= {1'b0, ts_bad, id_bad};
            pass       <= !(ts_bad || id_bad);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (tmo) begin
            fail_flags <= {1'b1, 1'b0, id_bad};
            m_read     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (accept) state <= is_id ? ID_WAIT : TS_WAIT;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mpsoc_sysid_checker.sv
// tb_mpsoc_sysid_checker: randomized self-checking bench with a scripted Avalon slave and a timing model
module tb_mpsoc_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd1;
  localparam logic [31:0] EXP_TS = 32'd1716034729;
  localparam int T = 8;
  logic clock = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic busy, done, pass, m_read;
  logic [2:0] fail_flags;
  logic [31:0] id_value, ts_value, m_address;
  logic m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [31:0] m_readdata = '0;
  int vectors = 0, errors = 0, cyc = 0;
  int wait_c[2], dly_c[2], reads[2];
  logic [31:0] data_c[2];
  int phase = 0, stall = 0, pend = 0, pidx = 0;
  bit in_req = 0, stray = 0;
  logic [31:0] prev_addr = '0;
  int done_q[$];

  mpsoc_sysid_checker #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_flags(fail_flags), .id_value(id_value), .ts_value(ts_value), .m_address(m_address),
    .m_read(m_read), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // one cycle: sample outputs at negedge, then play the slave for the coming posedge
  task automatic tick();
    int idx;
    @(negedge clock);
    cyc++;
    if (done === 1'b1) done_q.push_back(cyc);
    m_readdatavalid = 1'b0;
    m_waitrequest = 1'b0;
    if (stray) begin
      m_readdatavalid = 1'b1;
      m_readdata = 32'hDEAD_BEEF;
      stray = 0;
    end
    if (phase == 1) begin
      vectors++;
      if (m_read !== 1'b0) begin
        errors++;
        $display("FAIL wait_read_low: m_read=%b required 0 (cycle %0d)", m_read, cyc);
      end
      pend--;
      if (pend == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = data_c[pidx];
        phase = 0;
      end
    end else if (m_read === 1'b1) begin
      idx = int'(m_address[2]);
      if (in_req) begin
        vectors++;
        if (m_address !== prev_addr) begin
          errors++;
          $display("FAIL stall_addr: m_address=%h required %h (cycle %0d)", m_address, prev_addr, cyc);
        end
      end else begin
        in_req = 1;
        stall = wait_c[idx];
      end
      prev_addr = m_address;
      if (stall > 0) begin
        m_waitrequest = 1'b1;
        stall--;
      end else begin
        reads[idx]++;
        in_req = 0;
        pidx = idx;
        if (dly_c[idx] == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata = data_c[idx];
        end else begin
          phase = 1;
          pend = dly_c[idx];
        end
      end
    end else in_req = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && phase != 0; i++) tick();
  endtask

  // model: a read completes at counter index wait+delay unless that exceeds T-1
  task automatic run_check(input string name, input int w0, input int d0, input logic [31:0] v0,
                           input int w1, input int d1, input logic [31:0] v1);
    int k0, k1, off, c0, erd0, erd1;
    bit c_id, c_ts, ep;
    logic [2:0] ef;
    logic [31:0] eid, ets;
    wait_c[0] = w0; dly_c[0] = d0; data_c[0] = v0;
    wait_c[1] = w1; dly_c[1] = d1; data_c[1] = v1;
    k0 = w0 + d0;
    k1 = w1 + d1;
    c_id = k0 <= T - 1;
    c_ts = c_id && k1 <= T - 1;
    erd0 = w0 <= T - 1 ? 1 : 0;
    erd1 = c_id && w1 <= T - 1 ? 1 : 0;
    off = !c_id ? 1 + T : !c_ts ? 2 + k0 + T : 3 + k0 + k1;
    eid = c_id ? v0 : 32'd0;
    ets = c_ts ? v1 : 32'd0;
    ef = {!c_ts, c_ts && v1 != EXP_TS, c_id && v0 != EXP_ID};
    ep = ef == 3'b000;
    reads[0] = 0;
    reads[1] = 0;
    tick();
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && cyc < c0 + 60) begin
      vectors++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: busy=%b required 1 (cycle %0d)", name, busy, cyc - c0);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || cyc - c0 != off) begin
      errors++;
      $display("FAIL %s done_time: done=%b at offset %0d required 1 at offset %0d", name, done, cyc - c0, off);
    end
    vectors++;
    if (pass !== ep || fail_flags !== ef) begin
      errors++;
      $display("FAIL %s verdict: pass=%b flags=%b required pass=%b flags=%b", name, pass, fail_flags, ep, ef);
    end
    vectors++;
    if (id_value !== eid || ts_value !== ets) begin
      errors++;
      $display("FAIL %s values: id=%h ts=%h required id=%h ts=%h", name, id_value, ts_value, eid, ets);
    end
    vectors++;
    if (busy !== 1'b0 || m_read !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: busy=%b m_read=%b required 0 0", name, busy, m_read);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || pass !== ep || fail_flags !== ef || id_value !== eid) begin
      errors++;
      $display("FAIL %s hold: done=%b pass=%b flags=%b id=%h required 0 %b %b %h", name, done, pass, fail_flags, id_value, ep, ef, eid);
    end
    drain();
    vectors++;
    if (reads[0] != erd0 || reads[1] != erd1) begin
      errors++;
      $display("FAIL %s reads: id=%0d ts=%0d required %0d %0d", name, reads[0], reads[1], erd0, erd1);
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_flags !== 3'b000 || id_value !== 32'd0 ||
        ts_value !== 32'd0 || m_read !== 1'b0 || m_address !== 32'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b pass=%b flags=%b id=%h ts=%h rd=%b addr=%h required all zero",
               name, busy, done, pass, fail_flags, id_value, ts_value, m_read, m_address);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1 check_idle("reset_async");
    tick();
    tick();
    check_idle("reset_held");
    reset_n = 1'b1;
    tick();
    check_idle("reset_released");
  endtask

  task automatic test_zero_wait();
    run_check("zero_wait", 0, 0, EXP_ID, 0, 0, EXP_TS);
  endtask

  task automatic test_stall();
    run_check("stall", 4, 2, EXP_ID, 4, 2, EXP_TS);
  endtask

  task automatic test_mismatch();
    run_check("id_mismatch", 0, 0, 32'd2, 0, 0, EXP_TS);
    run_check("ts_mismatch", 1, 1, EXP_ID, 0, 1, EXP_TS + 32'd1);
  endtask

  task automatic test_timeout();
    logic [31:0] id_h, ts_h;
    logic [2:0] f_h;
    run_check("ts_timeout", 0, 0, EXP_ID, 1000, 0, EXP_TS);
    id_h = id_value; ts_h = ts_value; f_h = fail_flags;
    stray = 1;
    tick();
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || id_value !== id_h || ts_value !== ts_h || fail_flags !== f_h) begin
      errors++;
      $display("FAIL stray_rdv: done=%b busy=%b id=%h ts=%h flags=%b required 0 0 %h %h %b", done, busy, id_value, ts_value, fail_flags, id_h, ts_h, f_h);
    end
    run_check("id_timeout", 1000, 0, EXP_ID, 0, 0, EXP_TS);
  endtask

  task automatic test_boundary();
    run_check("edge_id_data", 3, 4, EXP_ID, 7, 0, EXP_TS);
    run_check("edge_ts_data", 0, 0, EXP_ID, 2, 5, EXP_TS);
    run_check("edge_late", 3, 5, EXP_ID, 0, 0, EXP_TS);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_check("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                $urandom_range(0, 1) != 0 ? EXP_ID : $urandom,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                $urandom_range(0, 1) != 0 ? EXP_TS : $urandom);
  endtask

  task automatic test_back_to_back();
    int c0;
    wait_c[0] = 0; dly_c[0] = 0; data_c[0] = EXP_ID;
    wait_c[1] = 0; dly_c[1] = 0; data_c[1] = EXP_TS;
    reads[0] = 0;
    reads[1] = 0;
    done_q.delete();
    tick();
    start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (done_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses required 4", done_q.size());
    end
    for (int i = 0; i < done_q.size() && i < 4; i++) begin
      vectors++;
      if (done_q[i] - c0 != 3 + 4 * i) begin
        errors++;
        $display("FAIL b2b_time: done %0d at offset %0d required %0d", i, done_q[i] - c0, 3 + 4 * i);
      end
    end
    vectors++;
    if (reads[0] != 4 || reads[1] != 4 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: reads=%0d/%0d pass=%b busy=%b required 4/4 1 0", reads[0], reads[1], pass, busy);
    end
  endtask

  task automatic test_reset_mid();
    wait_c[0] = 1; dly_c[0] = 4; data_c[0] = EXP_ID;
    wait_c[1] = 0; dly_c[1] = 0; data_c[1] = EXP_TS;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && phase != 1; i++) tick();
    tick();
    vectors++;
    if (busy !== 1'b1 || m_read !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: busy=%b m_read=%b required 1 0", busy, m_read);
    end
    #1 reset_n = 1'b0;
    #1 check_idle("mid_reset");
    tick();
    reset_n = 1'b1;
    drain();
    tick();
    check_idle("late_rdv");
    run_check("after_reset", 0, 0, EXP_ID, 0, 0, EXP_TS);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_mismatch();
    test_timeout();
    test_boundary();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
